// File: rtl/econet_pkg.sv
// Shared Econet line constants, controller states and the CRC-16/X.25 bit step.
// Used by both the transmit framer and the receiver.
package econet_pkg;

  localparam logic [7:0]  ECO_FLAG       = 8'h7E;
  localparam logic [15:0] FCS_INIT       = 16'hFFFF;
  localparam logic [15:0] FCS_POLY       = 16'h8408;
  localparam logic [15:0] FCS_GOOD       = 16'hF0B8;
  localparam int          ECO_ABORT_ONES = 8;

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    DATA,
    FCS,
    CLOSE,
    ABORT
  } eco_state_e;

  function automatic logic [15:0] fcs16_step(input logic [15:0] crc,
                                             input logic        b,
                                             input logic [15:0] poly);
    logic fb;
    fb = crc[0] ^ b;
    return fb ? ((crc >> 1) ^ poly) : (crc >> 1);
  endfunction

endpackage

// File: rtl/econet_fcs16.sv
// Bit-serial CRC-16/X.25 (reflected). init presets the register, en folds one bit in.
module econet_fcs16
  import econet_pkg::*;
#(
  parameter logic [15:0] INIT = 16'hFFFF,
  parameter logic [15:0] POLY = 16'h8408
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = INIT;
    end else if (en_i) begin
      crc_d = fcs16_step(crc_q, bit_i, POLY);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/econet_tx_framer.sv
// Econet HDLC frame transmitter: flags, bit-stuffed buffer bytes, inverted CRC-16/X.25, flag.
// Line outputs are registered, so the line runs one clock behind the controller state.
module econet_tx_framer #(
  parameter int          ADDR_WIDTH     = 11,
  parameter int          PREAMBLE_FLAGS = 1,
  parameter logic [15:0] FCS_INIT       = econet_pkg::FCS_INIT,
  parameter logic [15:0] FCS_POLY       = econet_pkg::FCS_POLY
) (
  input  logic                  econet_clk,
  input  logic                  valid_rst,
  input  logic                  tx_start,
  input  logic [ADDR_WIDTH-1:0] tx_base,
  input  logic [ADDR_WIDTH-1:0] tx_len,
  input  logic                  abort,
  output logic                  buf_rd,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  input  logic [7:0]            buf_data,
  output logic                  tx_data,
  output logic                  tx_en,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  err
);

  import econet_pkg::*;

  localparam logic [2:0] STUFF_RUN  = 3'd5;
  localparam logic [2:0] ABORT_LAST = 3'(ECO_ABORT_ONES - 1);
  localparam logic [3:0] FLAGS_LAST = 4'(PREAMBLE_FLAGS - 1);

  eco_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [2:0]            ones_q, ones_d;
  logic [3:0]            flag_cnt_q, flag_cnt_d;
  logic [7:0]            sh_q, sh_d;
  logic [7:0]            nxt_q, nxt_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_q, rd_d, rd_dly_q;
  logic                  fcs_hi_q, fcs_hi_d;
  logic                  tx_data_q, tx_data_d;
  logic                  tx_en_q, tx_en_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  err_q, err_d;
  logic                  done_pend_q, done_pend_d;
  logic                  abort_pend_q, abort_pend_d;
  logic                  crc_init, crc_en, load_byte, stuff_now;
  logic [15:0]           crc;

  econet_fcs16 #(
    .INIT(FCS_INIT),
    .POLY(FCS_POLY)
  ) u_fcs (
    .clk_i (econet_clk),
    .rst_i (valid_rst),
    .init_i(crc_init),
    .en_i  (crc_en),
    .bit_i (sh_q[0]),
    .crc_o (crc)
  );

  assign stuff_now = (ones_q == STUFF_RUN);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    flag_cnt_d   = flag_cnt_q;
    sh_d         = sh_q;
    nxt_d        = rd_dly_q ? buf_data : nxt_q;
    rem_d        = rem_q;
    addr_d       = addr_q;
    rd_d         = 1'b0;
    fcs_hi_d     = fcs_hi_q;
    tx_data_d    = 1'b1;
    tx_en_d      = 1'b0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    err_d        = 1'b0;
    done_pend_d  = 1'b0;
    abort_pend_d = 1'b0;
    crc_init     = 1'b0;
    crc_en       = 1'b0;
    load_byte    = 1'b0;

    case (state_q)
      IDLE: begin
        // End pulses line up with the clock that drops tx_en.
        done_d    = done_pend_q;
        aborted_d = abort_pend_q;
        if (tx_start && !tx_en_q) begin
          if (tx_len == '0) begin
            err_d = 1'b1;
          end else begin
            addr_d     = tx_base;
            rem_d      = tx_len;
            rd_d       = 1'b1;
            crc_init   = 1'b1;
            bit_cnt_d  = '0;
            flag_cnt_d = '0;
            ones_d     = '0;
            fcs_hi_d   = 1'b0;
            state_d    = OPEN;
          end
        end
      end

      OPEN: begin
        tx_en_d   = 1'b1;
        tx_data_d = ECO_FLAG[bit_cnt_q];
        ones_d    = '0;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (flag_cnt_q == FLAGS_LAST) begin
            state_d   = DATA;
            load_byte = 1'b1;
          end else begin
            flag_cnt_d = flag_cnt_q + 4'd1;
          end
        end
      end

      DATA: begin
        tx_en_d = 1'b1;
        if (stuff_now) begin
          tx_data_d = 1'b0;
          ones_d    = '0;
        end else begin
          tx_data_d = sh_q[0];
          crc_en    = 1'b1;
          ones_d    = sh_q[0] ? ones_q + 3'd1 : 3'd0;
          sh_d      = {1'b0, sh_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (rem_q == '0) begin
              state_d = FCS;
            end else begin
              load_byte = 1'b1;
            end
          end
        end
      end

      FCS: begin
        tx_en_d = 1'b1;
        if (stuff_now) begin
          tx_data_d = 1'b0;
          ones_d    = '0;
        end else begin
          tx_data_d = ~crc[{fcs_hi_q, bit_cnt_q}];
          ones_d    = tx_data_d ? ones_q + 3'd1 : 3'd0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (fcs_hi_q) begin
              state_d = CLOSE;
            end else begin
              fcs_hi_d = 1'b1;
            end
          end
        end
      end

      CLOSE: begin
        // A run of five from the last FCS bit still owes its stuffed zero.
        tx_en_d = 1'b1;
        ones_d  = '0;
        if (stuff_now) begin
          tx_data_d = 1'b0;
        end else begin
          tx_data_d = ECO_FLAG[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d     = IDLE;
            done_pend_d = 1'b1;
          end
        end
      end

      ABORT: begin
        tx_en_d   = 1'b1;
        tx_data_d = 1'b1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == ABORT_LAST) begin
          state_d      = IDLE;
          abort_pend_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Move the prefetched byte into the shifter and fetch the one after it.
    if (load_byte) begin
      sh_d  = nxt_q;
      rem_d = rem_q - 1'b1;
      if (rem_q > ADDR_WIDTH'(1)) begin
        rd_d   = 1'b1;
        addr_d = addr_q + 1'b1;
      end
    end

    // The first abort one replaces the bit that would have gone out this clock.
    if (abort && (state_q == OPEN || state_q == DATA || state_q == FCS)) begin
      state_d   = ABORT;
      tx_en_d   = 1'b1;
      tx_data_d = 1'b1;
      bit_cnt_d = 3'd1;
      ones_d    = '0;
      crc_en    = 1'b0;
      rd_d      = 1'b0;
      addr_d    = addr_q;
      sh_d      = sh_q;
      rem_d     = rem_q;
      fcs_hi_d  = fcs_hi_q;
    end
  end

  always_ff @(posedge econet_clk or posedge valid_rst) begin
    if (valid_rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      ones_q       <= '0;
      flag_cnt_q   <= '0;
      sh_q         <= '0;
      nxt_q        <= '0;
      rem_q        <= '0;
      addr_q       <= '0;
      rd_q         <= 1'b0;
      rd_dly_q     <= 1'b0;
      fcs_hi_q     <= 1'b0;
      tx_data_q    <= 1'b1;
      tx_en_q      <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      err_q        <= 1'b0;
      done_pend_q  <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_q       <= ones_d;
      flag_cnt_q   <= flag_cnt_d;
      sh_q         <= sh_d;
      nxt_q        <= nxt_d;
      rem_q        <= rem_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      rd_dly_q     <= rd_q;
      fcs_hi_q     <= fcs_hi_d;
      tx_data_q    <= tx_data_d;
      tx_en_q      <= tx_en_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      err_q        <= err_d;
      done_pend_q  <= done_pend_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign buf_rd   = rd_q;
  assign buf_addr = addr_q;
  assign tx_data  = tx_data_q;
  assign tx_en    = tx_en_q;
  assign busy     = (state_q != IDLE) || tx_en_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign err      = err_q;

endmodule
